// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller driven by mid-bit ticks from a baud generator
// Optional odd/even parity; good bytes, frame errors and parity errors are reported as one-cycle strobes.
module uart_rx_ctrl #(
  parameter int PARITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       bps_clk,
  output logic       bps_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bit_cnt_q;
  logic        par_q;
  logic        bps_en_q, rx_valid_q, rx_frame_err_q, rx_parity_err_q, rx_busy_q;
  logic [7:0]  rx_data_q;
  logic        fall_edge;
  logic        parity_ok;

  assign fall_edge = !sync2_q && sync3_q;

  always_comb begin
    parity_ok = 1'b1;
    if (PARITY == 1)      parity_ok = (^{shreg_q, par_q}) == 1'b1;
    else if (PARITY == 2) parity_ok = (^{shreg_q, par_q}) == 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      sync3_q         <= 1'b1;
      shreg_q         <= 8'h00;
      bit_cnt_q       <= 3'd0;
      par_q           <= 1'b0;
      bps_en_q        <= 1'b0;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      sync1_q         <= rs232_rx;
      sync2_q         <= sync1_q;
      sync3_q         <= sync2_q;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fall_edge) begin
            state_q   <= S_START;
            bps_en_q  <= 1'b1;
            rx_busy_q <= 1'b1;
            bit_cnt_q <= 3'd0;
          end
        end
        S_START: begin
          // A high sample at mid start bit means the edge was only a glitch.
          if (bps_clk) begin
            if (sync2_q) begin
              state_q   <= S_IDLE;
              bps_en_q  <= 1'b0;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (bps_clk) begin
            shreg_q   <= {sync2_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (bps_clk) begin
            par_q   <= sync2_q;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bps_clk) begin
            bps_en_q <= 1'b0;
            if (sync2_q) begin
              state_q   <= S_IDLE;
              rx_busy_q <= 1'b0;
              if (parity_ok) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
              end else begin
                rx_parity_err_q <= 1'b1;
              end
            end else begin
              rx_frame_err_q <= 1'b1;
              state_q        <= S_WAIT_HI;
            end
          end
        end
        S_WAIT_HI: begin
          // Held-low line (break) must return high before another start is accepted.
          if (sync2_q) begin
            state_q   <= S_IDLE;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bps_en_q  <= 1'b0;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bps_en        = bps_en_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl, no-parity and even-parity instances
// Lines are driven at bit level; a behavioural baud generator feeds each instance.
module tb_uart_rx_ctrl;

  localparam int BIT  = 32;
  localparam int HALF = BIT / 2;

  typedef struct packed {
    logic [2:0] kind;   // {valid, frame_err, parity_err}
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line0 = 1'b1, line1 = 1'b1;

  logic       en0, tick0, v0, fe0, pe0, busy0;
  logic       en1, tick1, v1, fe1, pe1, busy1;
  logic [7:0] d0, d1;
  int         bcnt0, bcnt1;

  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last_good [2];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.PARITY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line0), .bps_clk(tick0), .bps_en(en0),
    .rx_data(d0), .rx_valid(v0), .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_busy(busy0)
  );

  uart_rx_ctrl #(.PARITY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line1), .bps_clk(tick1), .bps_en(en1),
    .rx_data(d1), .rx_valid(v1), .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_busy(busy1)
  );

  // Baud generators: counter restarts whenever enable is low, first tick half a bit after enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt0 <= 0; tick0 <= 1'b0;
      bcnt1 <= 0; tick1 <= 1'b0;
    end else begin
      tick0 <= en0 && (bcnt0 == HALF - 1);
      bcnt0 <= (!en0 || bcnt0 == BIT - 1) ? 0 : bcnt0 + 1;
      tick1 <= en1 && (bcnt1 == HALF - 1);
      bcnt1 <= (!en1 || bcnt1 == BIT - 1) ? 0 : bcnt1 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic mon(input int ch, input logic [2:0] got, input logic [7:0] d);
    exp_t e;
    int   sz;
    if (got == 3'b000) return;
    checks++;
    sz = (ch == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL ch%0d unexpected strobe: got kind=%b data=%h, required no strobe", ch, got, d);
      return;
    end
    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
    if (got !== e.kind || d !== e.data) begin
      errors++;
      $display("FAIL ch%0d strobe: got kind=%b data=%h, required kind=%b data=%h",
               ch, got, d, e.kind, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, {v0, fe0, pe0}, d0);
      mon(1, {v1, fe1, pe1}, d1);
    end
  end

  task automatic drive(input int ch, input logic b, input int n);
    if (ch == 0) line0 = b; else line1 = b;
    repeat (n) @(negedge clk);
  endtask

  // Reference: stop low -> frame error; else parity (even, channel 1 only) -> parity error; else byte.
  task automatic expect_frame(input int ch, input logic [7:0] data, input logic p, input logic stop);
    exp_t e;
    if (!stop) begin
      e.kind = 3'b010; e.data = last_good[ch];
    end else if (ch == 1 && (^{data, p}) != 1'b0) begin
      e.kind = 3'b001; e.data = last_good[ch];
    end else begin
      e.kind = 3'b100; e.data = data; last_good[ch] = data;
    end
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic send(input int ch, input logic [7:0] data, input logic p, input logic stop, input int gap);
    expect_frame(ch, data, p, stop);
    drive(ch, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(ch, data[i], BIT);
    if (ch == 1) drive(ch, p, BIT);
    if (stop) begin
      drive(ch, 1'b1, BIT);
    end else begin
      drive(ch, 1'b0, 4 * BIT);
      chk($sformatf("ch%0d no restart while line low", ch), (ch == 0) ? en0 : en1, 1'b0);
      drive(ch, 1'b1, BIT);
    end
    if (gap > 0) drive(ch, 1'b1, gap);
  endtask

  task automatic wait_idle(input int ch);
    int n = 0;
    while (((ch == 0) ? busy0 : busy1) && n < 20 * BIT) begin
      @(negedge clk); n++;
    end
    chk($sformatf("ch%0d idle timeout", ch), (ch == 0) ? busy0 : busy1, 1'b0);
    chk($sformatf("ch%0d bps_en low when idle", ch), (ch == 0) ? en0 : en1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ch0 outputs"}, {en0, d0, v0, fe0, pe0, busy0}, 0);
    chk({tag, " ch1 outputs"}, {en1, d1, v1, fe1, pe1, busy1}, 0);
  endtask

  initial begin
    int en_cycles;
    int n;
    logic [7:0] rd;
    logic       rp, rs;

    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // No parity: single good byte
    send(0, 8'hA5, 1'b0, 1'b1, BIT);
    wait_idle(0);
    chk("A5 rx_data", d0, 8'hA5);

    // Glitch shorter than half a bit: generator runs briefly, nothing reported
    en_cycles = 0;
    line0 = 1'b0;
    for (int i = 0; i < 4 * BIT; i++) begin
      @(negedge clk);
      if (i == 5) line0 = 1'b1;
      if (en0) en_cycles++;
    end
    checks++;
    if (en_cycles < HALF || en_cycles > HALF + 3) begin
      errors++;
      $display("FAIL glitch bps_en width: got=%0d required=%0d..%0d", en_cycles, HALF, HALF + 3);
    end
    chk("glitch busy", busy0, 1'b0);
    chk("glitch rx_data", d0, last_good[0]);

    // Stop bit low, line held low, then recovery
    send(0, 8'h3C, 1'b0, 1'b0, BIT);
    wait_idle(0);
    chk("frame err keeps data", d0, 8'hA5);
    send(0, 8'h11, 1'b0, 1'b1, BIT);
    wait_idle(0);
    chk("11 rx_data", d0, 8'h11);

    // Even parity: wrong then right parity bit
    send(1, 8'h01, 1'b0, 1'b1, BIT);
    wait_idle(1);
    chk("parity err keeps data", d1, 8'h00);
    send(1, 8'h01, 1'b1, 1'b1, BIT);
    wait_idle(1);
    chk("01 rx_data", d1, 8'h01);

    // Back-to-back frames with no idle gap
    send(0, 8'h00, 1'b0, 1'b1, 0);
    send(0, 8'hFF, 1'b0, 1'b1, BIT);
    wait_idle(0);
    send(1, 8'h00, 1'b0, 1'b1, 0);
    send(1, 8'hFF, 1'b0, 1'b1, BIT);
    wait_idle(1);

    // Reset during D4 discards the partial byte
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, i[0], BIT);
    drive(0, 1'b0, HALF);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid-frame reset");
    line0 = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outputs("held reset");
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 8'h5A, 1'b0, 1'b1, BIT);
    wait_idle(0);
    chk("5A after reset", d0, 8'h5A);

    // Randomized traffic on both channels
    for (int k = 0; k < 40; k++) begin
      rd = 8'($urandom);
      rp = ^rd;
      if ($urandom_range(0, 3) == 0) rp = ~rp;
      rs = ($urandom_range(0, 5) != 0);
      n  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, BIT);
      send(k % 2, rd, rp, rs, n);
    end
    drive(0, 1'b1, BIT);
    wait_idle(0);
    wait_idle(1);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20 * BIT) begin
      @(negedge clk); n++;
    end
    chk("ch0 pending expectations", q0.size(), 0);
    chk("ch1 pending expectations", q1.size(), 0);
    chk("ch0 final data", d0, last_good[0]);
    chk("ch1 final data", d1, last_good[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
